// File: rtl/bitrev_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit bit-reverser between two requesters.
// Double-width ops take two beats through the same reverser; results are held until RespReady.
module bitrev_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               Req0Valid,
    input  logic               Req0Double,
    input  logic [2*WIDTH-1:0] Req0A,
    output logic               Req0Ready,
    input  logic               Req1Valid,
    input  logic               Req1Double,
    input  logic [2*WIDTH-1:0] Req1A,
    output logic               Req1Ready,
    output logic               RespValid,
    input  logic               RespReady,
    output logic [2*WIDTH-1:0] RespData,
    output logic               RespId,
    output logic               Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   op_q, op_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 dbl_q, dbl_d;
    logic                 id_q, id_d;
    logic                 last_q, last_d;

    logic                 gnt0, gnt1;
    logic [WIDTH-1:0]     rev_in;
    logic [WIDTH-1:0]     rev_out;

    // On contention the requester that was not granted last time wins.
    assign gnt0 = Req0Valid & (~Req1Valid | last_q);
    assign gnt1 = Req1Valid & (~Req0Valid | ~last_q);

    assign Req0Ready = (state_q == IDLE) & gnt0;
    assign Req1Ready = (state_q == IDLE) & gnt1;

    assign rev_in = (state_q == BEAT1) ? op_q[2*WIDTH-1:WIDTH] : op_q[WIDTH-1:0];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign rev_out[gi] = rev_in[WIDTH-1-gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        dbl_d   = dbl_q;
        id_d    = id_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (Req0Ready) begin
                    op_d    = Req0A;
                    dbl_d   = Req0Double;
                    id_d    = 1'b0;
                    last_d  = 1'b0;
                    state_d = BEAT0;
                end else if (Req1Ready) begin
                    op_d    = Req1A;
                    dbl_d   = Req1Double;
                    id_d    = 1'b1;
                    last_d  = 1'b1;
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                // Low half of the operand lands in the high half of a double result.
                if (dbl_q) begin
                    res_d[2*WIDTH-1:WIDTH] = rev_out;
                    state_d                = BEAT1;
                end else begin
                    res_d   = {{WIDTH{1'b0}}, rev_out};
                    state_d = DONE;
                end
            end
            BEAT1: begin
                res_d[WIDTH-1:0] = rev_out;
                state_d          = DONE;
            end
            DONE: begin
                if (RespReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            op_q    <= '0;
            res_q   <= '0;
            dbl_q   <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            dbl_q   <= dbl_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign RespValid = (state_q == DONE);
    assign RespData  = res_q;
    assign RespId    = id_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bitrev_arbiter.sv
// Randomized bench for bitrev_arbiter: stimulus pushes expected responses into a
// scoreboard, a negedge monitor checks grants, handshakes, latency and results.
module tb_bitrev_arbiter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rv0, rd0, rv1, rd1;
    logic [2*W-1:0] ra0, ra1;
    logic          Req0Ready, Req1Ready;
    logic          RespValid, RespReady, RespId, Busy;
    logic [2*W-1:0] RespData;

    bitrev_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .Req0Valid  (rv0),
        .Req0Double (rd0),
        .Req0A      (ra0),
        .Req0Ready  (Req0Ready),
        .Req1Valid  (rv1),
        .Req1Double (rd1),
        .Req1A      (ra1),
        .Req1Ready  (Req1Ready),
        .RespValid  (RespValid),
        .RespReady  (RespReady),
        .RespData   (RespData),
        .RespId     (RespId),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] data;
        logic           id;
        logic           dbl;
        int             acc_cyc;
    } exp_t;

    exp_t   sb[$];
    int     grants[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    logic   in_flight = 1'b0;
    logic   last_g = 1'b1;
    logic   head_seen = 1'b0;
    bit     acc0 = 0, acc1 = 0;
    logic [2*W-1:0] last_pop_data = '0;
    logic   last_pop_id = 1'b0;

    function automatic logic [2*W-1:0] golden(input logic [2*W-1:0] a, input logic dbl);
        logic [2*W-1:0] r;
        r = '0;
        if (dbl) begin
            for (int i = 0; i < 2*W; i++) r[i] = a[2*W-1-i];
        end else begin
            for (int i = 0; i < W; i++) r[i] = a[W-1-i];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / reference model: one transaction line per accept and per response.
    always @(negedge clk) begin
        logic e0, e1;
        exp_t h;
        if (resetn) begin
            e0 = !in_flight && rv0 && (!rv1 || last_g);
            e1 = !in_flight && rv1 && (!rv0 || !last_g);
            chk("req0_ready", {63'd0, Req0Ready}, {63'd0, e0});
            chk("req1_ready", {63'd0, Req1Ready}, {63'd0, e1});
            chk("busy", {63'd0, Busy}, {63'd0, in_flight && !(head_seen && !RespValid)});
            if (e0 || e1) begin
                h.id      = e1;
                h.dbl     = e1 ? rd1 : rd0;
                h.data    = golden(e1 ? ra1 : ra0, h.dbl);
                h.acc_cyc = cyc;
                sb.push_back(h);
                grants.push_back(e1 ? 1 : 0);
                last_g    = e1;
                in_flight = 1'b1;
                head_seen = 1'b0;
                if (e1) acc1 = 1; else acc0 = 1;
                $display("accept id=%0d dbl=%0d a=%h cyc=%0d", h.id, h.dbl, e1 ? ra1 : ra0, cyc);
            end else if (sb.size() > 0 && !head_seen) begin
                h = sb[0];
                if (cyc - h.acc_cyc == (h.dbl ? 3 : 2) && !RespValid)
                    chk("resp_missing", {63'd0, RespValid}, 64'd1);
            end
            if (RespValid) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", {63'd0, RespValid}, 64'd0);
                end else begin
                    h = sb[0];
                    if (!head_seen) begin
                        chk("latency", 64'(cyc - h.acc_cyc), 64'(h.dbl ? 3 : 2));
                        head_seen = 1'b1;
                    end
                    chk("resp_data", RespData, h.data);
                    chk("resp_id", {63'd0, RespId}, {63'd0, h.id});
                    if (RespReady) begin
                        void'(sb.pop_front());
                        in_flight     = 1'b0;
                        head_seen     = 1'b0;
                        last_pop_data = RespData;
                        last_pop_id   = RespId;
                        $display("resp id=%0d data=%h cyc=%0d", RespId, RespData, cyc);
                    end
                end
            end
        end
    end

    // One cycle of stimulus: held requests stay put until accepted.
    task automatic drive_cycle(input int pv, input int prr);
        @(posedge clk);
        #1;
        if (!(rv0 && !acc0)) begin
            rv0 = ($urandom_range(99) < pv);
            rd0 = $urandom_range(1);
            ra0 = {$urandom, $urandom};
        end
        if (!(rv1 && !acc1)) begin
            rv1 = ($urandom_range(99) < pv);
            rd1 = $urandom_range(1);
            ra1 = {$urandom, $urandom};
        end
        acc0 = 0;
        acc1 = 0;
        RespReady = ($urandom_range(99) < prr);
    endtask

    initial begin
        bit found;
        resetn = 1'b0;
        rv0 = 0; rv1 = 0; rd0 = 0; rd1 = 0; ra0 = '0; ra1 = '0;
        RespReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", {63'd0, RespValid}, 64'd0);
        chk("rst_resp_data", RespData, 64'd0);
        chk("rst_resp_id", {63'd0, RespId}, 64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        resetn = 1'b1;

        // Single op from requester 0
        rv0 = 1; rd0 = 0; ra0 = 64'h0000_0000_0000_0001;
        repeat (6) drive_cycle(0, 100);
        chk("t1_data", last_pop_data, 64'h0000_0000_8000_0000);
        chk("t1_id", {63'd0, last_pop_id}, 64'd0);

        // Double op from requester 1
        rv1 = 1; rd1 = 1; ra1 = 64'h0000_0000_0000_0001;
        repeat (7) drive_cycle(0, 100);
        chk("t2_data", last_pop_data, 64'h8000_0000_0000_0000);
        chk("t2_id", {63'd0, last_pop_id}, 64'd1);

        // Both requesters continuously valid
        grants.delete();
        repeat (24) drive_cycle(100, 100);
        if (grants.size() < 4) begin
            chk("fair_count", 64'(grants.size()), 64'd4);
        end else begin
            for (int i = 0; i < 4; i++)
                chk("fair_order", 64'(grants[i]), 64'(i % 2));
        end
        repeat (8) drive_cycle(0, 100);

        // Stall in DONE with new requests pending
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            drive_cycle(100, 0);
            if (RespValid) found = 1;
        end
        chk("stall_reach_done", {63'd0, found}, 64'd1);
        repeat (5) drive_cycle(100, 0);
        repeat (10) drive_cycle(0, 100);

        // Reset while in BEAT1
        rv0 = 0; rv1 = 1; rd1 = 1; ra1 = {$urandom, $urandom};
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #1;
            if (acc1) found = 1;
        end
        chk("rst_test_accept", {63'd0, found}, 64'd1);
        rv1 = 0; acc1 = 0;
        @(posedge clk);
        #2;
        chk("beat1_busy", {63'd0, Busy}, 64'd1);
        resetn = 1'b0;
        #1;
        chk("midrst_resp_valid", {63'd0, RespValid}, 64'd0);
        chk("midrst_busy", {63'd0, Busy}, 64'd0);
        sb.delete();
        in_flight = 1'b0;
        head_seen = 1'b0;
        last_g    = 1'b1;
        acc0 = 0; acc1 = 0;
        @(negedge clk);
        #2;
        resetn = 1'b1;
        grants.delete();
        @(posedge clk);
        #1;
        rv0 = 1; rv1 = 1; rd0 = 0; rd1 = 0; ra0 = {$urandom, $urandom}; ra1 = {$urandom, $urandom};
        repeat (8) drive_cycle(0, 100);
        if (grants.size() == 0) chk("post_rst_grant_count", 64'd0, 64'd1);
        else chk("post_rst_grant", 64'(grants[0]), 64'd0);

        // Random traffic
        repeat (2000) drive_cycle(50, 70);
        repeat (12) drive_cycle(0, 100);
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
